// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side packer: lane keep masks and counter widths.
package fifo_pkg;

    localparam int unsigned MAX_PACK  = 16;
    localparam int unsigned CNT_W_MAX = 5;

    // Width of a counter that must hold the values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 32'd1);
    endfunction

    // Contiguous keep flags for the lowest cnt lanes; callers truncate to their lane count.
    function automatic logic [31:0] keep_mask(input logic [CNT_W_MAX-1:0] cnt);
        return (32'd1 << cnt) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry valid/ready output buffer with a registered head and occupancy count.
module fifo_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [1:0]   buf_cnt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [W-1:0] head_nxt_s;
    logic [W-1:0] tail_nxt_s;
    logic [1:0]   cnt_r;
    logic [1:0]   cnt_nxt_s;
    logic         valid_r;
    logic         pop_s;

    // Next-state for the two entries; the producer never pushes while both are occupied.
    always_comb begin
        pop_s      = valid_r & out_ready;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        cnt_nxt_s  = cnt_r;
        case ({push, pop_s})
            2'b10: begin
                if (cnt_r == 2'd0) begin
                    head_nxt_s = push_data;
                end else begin
                    tail_nxt_s = push_data;
                end
                cnt_nxt_s = cnt_r + 2'd1;
            end
            2'b01: begin
                head_nxt_s = tail_r;
                cnt_nxt_s  = cnt_r - 2'd1;
            end
            2'b11: begin
                if (cnt_r == 2'd1) begin
                    head_nxt_s = push_data;
                end else begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = push_data;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // Entry, count and valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {W{1'b0}};
            tail_r  <= {W{1'b0}};
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            cnt_r   <= cnt_nxt_s;
            valid_r <= (cnt_nxt_s != 2'd0);
        end
    end

    assign buf_cnt   = cnt_r;
    assign out_valid = valid_r;
    assign out_data  = head_r;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops words from an async FIFO read port, packs PACK of them into one beat and
// streams beats out through a two-entry buffer; flush emits a partial beat with keep flags.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned PACK  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PACK*DSIZE-1:0] m_data,
    output logic [PACK-1:0]       m_keep
);

    localparam int unsigned BW = PACK * DSIZE;
    localparam int unsigned CW = cnt_width(PACK);
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK);

    logic [PACK-1:0][DSIZE-1:0] acc_data_r;
    logic [CW-1:0]              acc_cnt_r;
    logic [CW-1:0]              lane_s;
    logic                       flush_pend_r;
    logic [1:0]                 buf_cnt_s;
    logic                       room_s;
    logic                       flush_eff_s;
    logic                       xfer_s;
    logic                       pop_s;
    logic [PACK-1:0]            keep_s;
    logic [BW-1:0]              beat_s;
    logic [BW+PACK-1:0]         head_s;

    // Transfer and pop decisions; room uses only the registered count, so m_ready never reaches rinc.
    always_comb begin
        room_s      = (buf_cnt_s < 2'd2);
        flush_eff_s = flush | flush_pend_r;
        xfer_s      = room_s & ((acc_cnt_r == FULL_CNT) |
                                (flush_eff_s & (acc_cnt_r != {CW{1'b0}})));
        pop_s       = ~rrst & ~rempty & ((acc_cnt_r < FULL_CNT) | xfer_s);
        lane_s      = xfer_s ? {CW{1'b0}} : acc_cnt_r;
    end

    // Outgoing beat: lanes beyond the fill level are zeroed so stale words never leak.
    always_comb begin
        keep_s = PACK'(keep_mask(CNT_W_MAX'(acc_cnt_r)));
        beat_s = {BW{1'b0}};
        for (int i = 0; i < int'(PACK); i++) begin
            if (keep_s[i]) begin
                beat_s[i*DSIZE +: DSIZE] = acc_data_r[i];
            end else begin
                beat_s[i*DSIZE +: DSIZE] = {DSIZE{1'b0}};
            end
        end
    end

    // Accumulator fill, restart after a transfer, and deferred flush tracking.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc_data_r   <= {BW{1'b0}};
            acc_cnt_r    <= {CW{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                acc_cnt_r <= pop_s ? CW'(1) : {CW{1'b0}};
            end else if (pop_s) begin
                acc_cnt_r <= acc_cnt_r + CW'(1);
            end else begin
                acc_cnt_r <= acc_cnt_r;
            end
            if (xfer_s) begin
                flush_pend_r <= 1'b0;
            end else if (flush && (acc_cnt_r != {CW{1'b0}})) begin
                flush_pend_r <= 1'b1;
            end else begin
                flush_pend_r <= flush_pend_r;
            end
            for (int i = 0; i < int'(PACK); i++) begin
                if (pop_s && (lane_s == CW'(i))) begin
                    acc_data_r[i] <= rdata;
                end
            end
        end
    end

    fifo_skid2 #(
        .W(BW + PACK)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (xfer_s),
        .push_data ({keep_s, beat_s}),
        .buf_cnt   (buf_cnt_s),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (head_s)
    );

    assign rinc   = pop_s;
    assign m_data = head_s[BW-1:0];
    assign m_keep = head_s[BW+PACK-1:BW];

endmodule
